// File: rtl/mul_cdb_buffer_if.sv
// Multiplier result / CDB bundle for mul_cdb_buffer.
// Master is the environment side; slave is the buffer.
interface mul_cdb_buffer_if #(
    parameter int XLEN    = 32,
    parameter int PRF_LEN = 6,
    parameter int ROB_LEN = 5,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               mul_enable;
    logic               mul_valid;
    logic [XLEN-1:0]    mul_value;
    logic [PRF_LEN-1:0] mul_prf_idx;
    logic [ROB_LEN-1:0] mul_rob_idx;
    logic [XLEN-1:0]    mul_PC;
    logic               squash;
    logic               cdb_grant;
    logic               cdb_req;
    logic [XLEN-1:0]    cdb_value;
    logic [PRF_LEN-1:0] cdb_prf_idx;
    logic [ROB_LEN-1:0] cdb_rob_idx;
    logic [XLEN-1:0]    cdb_PC;
    logic               mul_issue_ok;
    logic [CW-1:0]      count;
    logic               overflow_err;

    modport master (
        output mul_enable, mul_valid, mul_value, mul_prf_idx,
        output mul_rob_idx, mul_PC, squash, cdb_grant,
        input  cdb_req, cdb_value, cdb_prf_idx, cdb_rob_idx,
        input  cdb_PC, mul_issue_ok, count, overflow_err
    );

    modport slave (
        input  mul_enable, mul_valid, mul_value, mul_prf_idx,
        input  mul_rob_idx, mul_PC, squash, cdb_grant,
        output cdb_req, cdb_value, cdb_prf_idx, cdb_rob_idx,
        output cdb_PC, mul_issue_ok, count, overflow_err
    );
endinterface

// File: rtl/mul_cdb_buffer.sv
// Multiplier result FIFO feeding the CDB arbiter, with issue-credit
// tracking and squash-time discard of wrong-path in-flight results.
module mul_cdb_buffer #(
    parameter int XLEN       = 32,
    parameter int PRF_LEN    = 6,
    parameter int ROB_LEN    = 5,
    parameter int DEPTH      = 4,
    parameter int PIPE_DEPTH = 8
) (
    input logic            clock,
    input logic            reset,
    mul_cdb_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(PIPE_DEPTH + DEPTH + 1);

    logic [XLEN-1:0]    r_value [DEPTH];
    logic [PRF_LEN-1:0] r_prf   [DEPTH];
    logic [ROB_LEN-1:0] r_rob   [DEPTH];
    logic [XLEN-1:0]    r_pc    [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_inflight;
    logic [IW-1:0] r_discard;
    logic          r_ovf;

    logic          w_full;
    logic          w_req;
    logic          w_pop;
    logic          w_take;
    logic          w_push;
    logic          w_drop;
    logic [IW-1:0] w_inflight_nxt;
    logic [IW:0]   w_occ;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_req  = (r_count != '0);
    assign w_pop  = w_req & bus.cdb_grant & ~bus.squash;
    // Results owed to a squash are swallowed before they reach the FIFO.
    assign w_take = bus.mul_valid & (r_discard == '0);
    assign w_push = w_take & (~w_full | w_pop) & ~bus.squash;
    assign w_drop = w_take & w_full & ~w_pop & ~bus.squash;

    assign w_inflight_nxt = r_inflight
                          + IW'(bus.mul_enable)
                          - IW'(bus.mul_valid);

    assign w_occ = (IW+1)'(r_count) + (IW+1)'(r_inflight);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (bus.squash) begin
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
                r_discard <= w_inflight_nxt;
            end else begin
                if (bus.mul_valid && r_discard != '0)
                    r_discard <= r_discard - IW'(1);
                if (w_push)
                    r_tail <= r_tail + AW'(1);
                if (w_pop)
                    r_head <= r_head + AW'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + CW'(1);
                else if (w_pop && !w_push)
                    r_count <= r_count - CW'(1);
                if (w_drop)
                    r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_value[i] <= '0;
                r_prf[i]   <= '0;
                r_rob[i]   <= '0;
                r_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_value[r_tail] <= bus.mul_value;
            r_prf[r_tail]   <= bus.mul_prf_idx;
            r_rob[r_tail]   <= bus.mul_rob_idx;
            r_pc[r_tail]    <= bus.mul_PC;
        end
    end

    assign bus.cdb_req      = w_req;
    assign bus.cdb_value    = r_value[r_head];
    assign bus.cdb_prf_idx  = r_prf[r_head];
    assign bus.cdb_rob_idx  = r_rob[r_head];
    assign bus.cdb_PC       = r_pc[r_head];
    assign bus.mul_issue_ok = (w_occ < (IW+1)'(DEPTH));
    assign bus.count        = r_count;
    assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_mul_cdb_buffer.sv
// Bench for mul_cdb_buffer: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mul_cdb_buffer;
    localparam int XLEN = 32;
    localparam int PL   = 6;
    localparam int RL   = 5;
    localparam int DEP  = 4;
    localparam int PIPE = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    mul_cdb_buffer_if #(.XLEN(XLEN), .PRF_LEN(PL), .ROB_LEN(RL), .DEPTH(DEP)) bus ();

    mul_cdb_buffer #(
        .XLEN(XLEN), .PRF_LEN(PL), .ROB_LEN(RL), .DEPTH(DEP), .PIPE_DEPTH(PIPE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        en;
        logic        vld;
        logic        grant;
        logic        sq;
        logic [31:0] val;
        logic        ereq;
        logic [31:0] eval;
        int          ecnt;
        logic        eok;
        logic        eovf;
    } row_t;

    typedef struct {
        logic [31:0] v;
        logic [5:0]  p;
        logic [4:0]  r;
        logic [31:0] pc;
    } ent_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.mul_enable  = 0;
        bus.mul_valid   = 0;
        bus.mul_value   = '0;
        bus.mul_prf_idx = '0;
        bus.mul_rob_idx = '0;
        bus.mul_PC      = '0;
        bus.squash      = 0;
        bus.cdb_grant   = 0;
    endtask

    task automatic drv(input logic en, input logic vld, input logic gr,
                       input logic sq, input logic [31:0] v);
        bus.mul_enable  = en;
        bus.mul_valid   = vld;
        bus.cdb_grant   = gr;
        bus.squash      = sq;
        bus.mul_value   = v;
        bus.mul_prf_idx = v[5:0];
        bus.mul_rob_idx = v[4:0];
        bus.mul_PC      = {v[29:0], 2'b00};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic req, input logic [31:0] v,
                           input int cnt, input logic ok, input logic ovf);
        chk({nm, ".req"}, 64'(bus.cdb_req), 64'(req));
        chk({nm, ".count"}, 64'(bus.count), 64'(cnt));
        chk({nm, ".issue_ok"}, 64'(bus.mul_issue_ok), 64'(ok));
        chk({nm, ".ovf"}, 64'(bus.overflow_err), 64'(ovf));
        if (req) begin
            chk({nm, ".value"}, 64'(bus.cdb_value), 64'(v));
            chk({nm, ".prf"}, 64'(bus.cdb_prf_idx), 64'(v[5:0]));
            chk({nm, ".rob"}, 64'(bus.cdb_rob_idx), 64'(v[4:0]));
            chk({nm, ".pc"}, 64'(bus.cdb_PC), 64'({v[29:0], 2'b00}));
        end
    endtask

    function automatic row_t mk(logic en, logic vld, logic gr, logic sq,
                                logic [31:0] v, logic ereq, logic [31:0] ev,
                                int ec, logic eok, logic eovf);
        row_t r;
        r.en = en; r.vld = vld; r.grant = gr; r.sq = sq; r.val = v;
        r.ereq = ereq; r.eval = ev; r.ecnt = ec; r.eok = eok; r.eovf = eovf;
        return r;
    endfunction

    row_t tbl[12];
    ent_t q[$];

    initial begin
        localparam logic [31:0] A = 32'hA0A, B = 32'hB0B, C = 32'hC0C;
        localparam logic [31:0] D = 32'hD0D, E = 32'hE0E, F = 32'hF0F;
        localparam logic [31:0] T1V = 32'h0000_1234;
        int   inflight;
        int   discard;
        logic movf;
        logic en, vld, gr, sq;
        ent_t e;
        bit   popped;

        idle();
        // T1 (T1V has prf=0x34->idx low bits; fields derived from value)
        tbl[0]  = mk(1, 1, 0, 0, T1V, 1, T1V, 1, 1, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0,   0, 0,   0, 1, 0);
        // T2 fill, order
        tbl[2]  = mk(1, 1, 0, 0, A, 1, A, 1, 1, 0);
        tbl[3]  = mk(1, 1, 0, 0, B, 1, A, 2, 1, 0);
        tbl[4]  = mk(1, 1, 0, 0, C, 1, A, 3, 1, 0);
        tbl[5]  = mk(1, 1, 0, 0, D, 1, A, 4, 0, 0);
        // T3 full push+pop, then a lost push
        tbl[6]  = mk(1, 1, 1, 0, E, 1, B, 4, 0, 0);
        tbl[7]  = mk(1, 1, 0, 0, F, 1, B, 4, 0, 1);
        tbl[8]  = mk(0, 0, 1, 0, 0, 1, C, 3, 1, 1);
        tbl[9]  = mk(0, 0, 1, 0, 0, 1, D, 2, 1, 1);
        tbl[10] = mk(0, 0, 1, 0, 0, 1, E, 1, 1, 1);
        tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);

        #2;
        chk_out("rst", 0, 0, 0, 1, 0);
        chk("rst.value", 64'(bus.cdb_value), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            drv(tbl[i].en, tbl[i].vld, tbl[i].grant, tbl[i].sq, tbl[i].val);
            step();
            chk_out($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eval,
                    tbl[i].ecnt, tbl[i].eok, tbl[i].eovf);
        end

        // T4 credit
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 0);
            step();
            chk_out($sformatf("t4.iss%0d", i), 0, 0, 0, (i < 3), 0);
        end
        drv(0, 1, 0, 0, 32'h44);
        step();
        chk_out("t4.arrive", 1, 32'h44, 1, 0, 0);
        drv(0, 0, 1, 0, 0);
        step();
        chk_out("t4.pop", 0, 0, 0, 1, 0);

        // T5 squash with 2 buffered and 3 in flight
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 0, 0);
            step();
        end
        drv(0, 1, 0, 0, 32'h51);
        step();
        drv(0, 1, 0, 0, 32'h52);
        step();
        chk_out("t5.pre", 1, 32'h51, 2, 0, 0);
        drv(0, 0, 1, 1, 0);
        step();
        chk_out("t5.sq", 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 0, 0, 32'h61 + i);
            step();
            chk_out($sformatf("t5.drop%0d", i), 0, 0, 0, 1, 0);
        end
        drv(1, 1, 0, 0, 32'h77);
        step();
        chk_out("t5.keep", 1, 32'h77, 1, 1, 0);

        // T6 async reset between edges
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 0, 32'h90 + i);
            step();
        end
        chk_out("t6.pre", 1, 32'h90, 3, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        chk_out("t6.async", 0, 0, 0, 1, 0);
        chk("t6.value", 64'(bus.cdb_value), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Random traffic against the reference model
        do_reset();
        q.delete();
        inflight = 0;
        discard  = 0;
        movf     = 0;
        for (int c = 0; c < 600; c++) begin
            en  = ((q.size() + inflight) < DEP) && ($urandom_range(0, 99) < 60);
            vld = (inflight > 0) && ($urandom_range(0, 99) < 55);
            gr  = ($urandom_range(0, 99) < 45);
            sq  = ($urandom_range(0, 99) < 4);
            e.v  = $urandom;
            e.p  = 6'($urandom);
            e.r  = 5'($urandom);
            e.pc = $urandom;
            bus.mul_enable  = en;
            bus.mul_valid   = vld;
            bus.cdb_grant   = gr;
            bus.squash      = sq;
            bus.mul_value   = e.v;
            bus.mul_prf_idx = e.p;
            bus.mul_rob_idx = e.r;
            bus.mul_PC      = e.pc;

            if (sq) begin
                q.delete();
                inflight = inflight + int'(en) - int'(vld);
                discard  = inflight;
            end else begin
                popped = (q.size() > 0) && gr;
                if (popped)
                    void'(q.pop_front());
                if (vld) begin
                    if (discard > 0)
                        discard--;
                    else if (q.size() < DEP)
                        q.push_back(e);
                    else
                        movf = 1;
                end
                inflight = inflight + int'(en) - int'(vld);
            end

            @(posedge clock);
            #1;
            idle();
            chk("rnd.req", 64'(bus.cdb_req), 64'(q.size() > 0));
            chk("rnd.count", 64'(bus.count), 64'(q.size()));
            chk("rnd.issue_ok", 64'(bus.mul_issue_ok),
                64'((q.size() + inflight) < DEP));
            chk("rnd.ovf", 64'(bus.overflow_err), 64'(movf));
            if (q.size() > 0) begin
                chk("rnd.value", 64'(bus.cdb_value), 64'(q[0].v));
                chk("rnd.prf", 64'(bus.cdb_prf_idx), 64'(q[0].p));
                chk("rnd.rob", 64'(bus.cdb_rob_idx), 64'(q[0].r));
                chk("rnd.pc", 64'(bus.cdb_PC), 64'(q[0].pc));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
